// File: rtl/sp_ram_ctrl_pkg.sv
// Shared types and constants for the single-port RAM front-end controller.
package sp_ram_ctrl_pkg;

  localparam logic GNT_WR    = 1'b0;
  localparam logic GNT_RD    = 1'b1;
  localparam int   BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_WR   = 2'd1,
    GRANT_RD   = 2'd2
  } grant_e;

  // A read may issue only if its data is guaranteed a buffer slot on arrival.
  function automatic logic credit_ok(input logic [1:0] cnt, input logic inflight, input logic pop);
    logic [2:0] occ;
    occ = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
    return (occ < 3'(BUF_DEPTH));
  endfunction

endpackage

// File: rtl/sp_ram_ctrl_if.sv
// Client and RAM-side bus of the single-port RAM front-end controller.
interface sp_ram_ctrl_if #(
  parameter int G_ADDR  = 6,
  parameter int G_WIDTH = 16
) ();
  logic               wr_req;
  logic [G_ADDR-1:0]  wr_addr;
  logic [G_WIDTH-1:0] wr_data;
  logic               wr_ack;
  logic               rd_req;
  logic [G_ADDR-1:0]  rd_addr;
  logic               rd_ack;
  logic               rd_vld;
  logic [G_WIDTH-1:0] rd_data;
  logic               rd_rdy;
  logic               ram_we;
  logic [G_ADDR-1:0]  ram_addr;
  logic [G_WIDTH-1:0] ram_din;
  logic [G_WIDTH-1:0] ram_dout;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, rd_rdy, ram_dout,
    output wr_ack, rd_ack, rd_vld, rd_data, ram_we, ram_addr, ram_din
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, rd_rdy, ram_dout,
    input  wr_ack, rd_ack, rd_vld, rd_data, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/sp_ram_rd_buf.sv
// Two-entry read-data FIFO; the head entry is a plain register so rd_data
// stays stable under backpressure.
module sp_ram_rd_buf #(
  parameter int G_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [G_WIDTH-1:0] din,
  input  logic               pop,
  output logic [G_WIDTH-1:0] dout,
  output logic               vld,
  output logic [1:0]         cnt
);
  logic [G_WIDTH-1:0] head_r, tail_r, head_s, tail_s;
  logic [1:0]         cnt_r, cnt_s;
  logic               vld_r;

  // Next-state for head/tail/count; head always holds the oldest entry.
  always_comb begin
    head_s = head_r;
    tail_s = tail_r;
    cnt_s  = cnt_r;
    case ({push, pop})
      2'b10: begin
        if (cnt_r == 2'd0) begin
          head_s = din;
          cnt_s  = 2'd1;
        end else if (cnt_r == 2'd1) begin
          tail_s = din;
          cnt_s  = 2'd2;
        end else begin
          cnt_s = cnt_r;
        end
      end
      2'b01: begin
        if (cnt_r != 2'd0) begin
          head_s = tail_r;
          cnt_s  = cnt_r - 2'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      2'b11: begin
        if (cnt_r == 2'd2) begin
          head_s = tail_r;
          tail_s = din;
        end else begin
          head_s = din;
          cnt_s  = 2'd1;
        end
      end
      default: begin
        cnt_s = cnt_r;
      end
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= {G_WIDTH{1'b0}};
      tail_r <= {G_WIDTH{1'b0}};
      cnt_r  <= 2'd0;
      vld_r  <= 1'b0;
    end else begin
      head_r <= head_s;
      tail_r <= tail_s;
      cnt_r  <= cnt_s;
      vld_r  <= (cnt_s != 2'd0);
    end
  end

  assign dout = head_r;
  assign vld  = vld_r;
  assign cnt  = cnt_r;
endmodule

// File: rtl/sp_ram_ctrl.sv
// Arbitrates one write and one read client onto a single-port RAM and
// returns read data through a credit-protected two-entry output buffer.
module sp_ram_ctrl
  import sp_ram_ctrl_pkg::*;
#(
  parameter int G_ADDR  = 6,
  parameter int G_WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  sp_ram_ctrl_if.slave bus
);
  logic               last_gnt_r;
  logic               inflight_r;
  logic               pop_s;
  logic               rd_ok_s;
  logic               buf_vld_s;
  logic [1:0]         buf_cnt_s;
  logic [G_WIDTH-1:0] buf_dout_s;
  grant_e             grant_s;

  assign pop_s   = buf_vld_s & bus.rd_rdy;
  assign rd_ok_s = credit_ok(buf_cnt_s, inflight_r, pop_s);

  // Round-robin arbitration between the write client and a credit-eligible read.
  always_comb begin
    grant_s = GRANT_NONE;
    if (rst) begin
      grant_s = GRANT_NONE;
    end else if (bus.wr_req && bus.rd_req && rd_ok_s) begin
      if (last_gnt_r == GNT_RD) begin
        grant_s = GRANT_WR;
      end else begin
        grant_s = GRANT_RD;
      end
    end else if (bus.wr_req) begin
      grant_s = GRANT_WR;
    end else if (bus.rd_req && rd_ok_s) begin
      grant_s = GRANT_RD;
    end else begin
      grant_s = GRANT_NONE;
    end
  end

  // Drive the RAM command and client acknowledges from the grant.
  always_comb begin
    bus.ram_we   = 1'b0;
    bus.ram_addr = {G_ADDR{1'b0}};
    bus.ram_din  = {G_WIDTH{1'b0}};
    bus.wr_ack   = 1'b0;
    bus.rd_ack   = 1'b0;
    case (grant_s)
      GRANT_WR: begin
        bus.ram_we   = 1'b1;
        bus.ram_addr = bus.wr_addr;
        bus.ram_din  = bus.wr_data;
        bus.wr_ack   = 1'b1;
      end
      GRANT_RD: begin
        bus.ram_addr = bus.rd_addr;
        bus.rd_ack   = 1'b1;
      end
      default: begin
        bus.ram_we = 1'b0;
      end
    endcase
  end

  // Last-grant and in-flight read tracking; reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_r <= GNT_RD;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= (grant_s == GRANT_RD);
      if (grant_s == GRANT_WR) begin
        last_gnt_r <= GNT_WR;
      end else if (grant_s == GRANT_RD) begin
        last_gnt_r <= GNT_RD;
      end else begin
        last_gnt_r <= last_gnt_r;
      end
    end
  end

  sp_ram_rd_buf #(.G_WIDTH(G_WIDTH)) u_rd_buf (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_r),
    .din  (bus.ram_dout),
    .pop  (pop_s),
    .dout (buf_dout_s),
    .vld  (buf_vld_s),
    .cnt  (buf_cnt_s)
  );

  assign bus.rd_vld  = buf_vld_s;
  assign bus.rd_data = buf_dout_s;
endmodule

// File: doc/sp_ram_ctrl.md
Name: sp_ram_ctrl

Overview:
- Front-end controller that sits directly upstream of the single-port block RAM (G_ADDR-bit address, G_WIDTH-bit data, 1-cycle registered read, read-first).
- Arbitrates one write client and one read client onto the single RAM port using req/ack handshakes.
- Captures RAM read data one cycle after issue and returns it through a 2-entry valid/ready output buffer with backpressure.
- Read issue is credit-limited so read data is never lost.

Parameters:
- G_ADDR, 6, RAM address width; depth = 2**G_ADDR.
- G_WIDTH, 16, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_req  in  1  write request; held until wr_ack.
- wr_addr  in  G_ADDR  write address.
- wr_data  in  G_WIDTH  write data.
- wr_ack  out  1  write accepted this cycle (combinational).
- rd_req  in  1  read request; held until rd_ack.
- rd_addr  in  G_ADDR  read address.
- rd_ack  out  1  read issued to RAM this cycle (combinational).
- rd_vld  out  1  read data valid at output.
- rd_data  out  G_WIDTH  read data.
- rd_rdy  in  1  consumer ready; transfer when rd_vld & rd_rdy.
- ram_we  out  1  RAM write enable.
- ram_addr  out  G_ADDR  RAM address.
- ram_din  out  G_WIDTH  RAM write data.
- ram_dout  in  G_WIDTH  RAM registered read data.

Behaviour:
- Issue rule: at most one RAM command per cycle. gnt_wr/gnt_rd are combinational from the requests, rd_ok and last_gnt.
- rd_ok = (buf_cnt + inflight - pop) < 2, where pop = rd_vld & rd_rdy this cycle. This credit check guarantees buffer space when ram_dout arrives.
- Only wr_req: grant write. Only rd_req & rd_ok: grant read. rd_req & !rd_ok: no read grant.
- Both eligible: round-robin. Grant the opposite of last_gnt, then update last_gnt to the granted client. last_gnt changes only on a grant.
- Write grant: ram_we=1, ram_addr=wr_addr, ram_din=wr_data, wr_ack=1.
- Read grant: ram_we=0, ram_addr=rd_addr, rd_ack=1.
- No grant: ram_we=0, ram_addr=0, ram_din=0.
- inflight register (1 bit) = gnt_rd. ram_dout is pushed into the buffer on the cycle after inflight is set.
- Read latency: rd_req in cycle N with empty buffer gives rd_ack in N and rd_vld in N+2 (RAM register, then buffer register).
- Output buffer is a 2-entry FIFO. Push and pop in the same cycle are allowed at any occupancy. rd_data holds the head entry and stays stable while rd_vld & !rd_rdy.
- Ordering: commands reach the RAM in grant order. A write to address A followed by a read of A returns the new data. A read in the same cycle as a write cannot occur.
- Sustained throughput: with rd_rdy=1, back-to-back reads run at one per cycle. Alternating wr/rd requests give 50% each.
- Reset (rst=1 on a clk edge), applies mid-operation as well:
  - buf_cnt=0, inflight=0, rd_vld=0, rd_data=0, last_gnt=RD (so the first tie goes to write).
  - While rst=1: wr_ack=0, rd_ack=0, ram_we=0.
  - Data in flight at reset is discarded.
- Boundary cases:
  - buf_cnt=2 and rd_rdy=0: reads are stalled and writes proceed.
  - buf_cnt=1, inflight=1, no pop: reads are stalled.
  - Address wrap is not applicable; addresses are used verbatim.

Decomposition:
- Shared header sp_ram_ctrl_defs.vh: localparams GNT_WR=1'b0, GNT_RD=1'b1, BUF_DEPTH=2.
- One sub-module, sp_ram_rd_buf: 2-entry synchronous FIFO with push/din/pop/dout/vld/cnt, same clk/rst convention.
- The arbiter and credit logic live in the top level.

Test Plan:
- Write 0x1234 to addr 5, then read addr 5 with rd_rdy=1: wr_ack at cycle 0, rd_ack at cycle 1, rd_vld=1 with rd_data=0x1234 at cycle 3 for exactly one cycle.
- wr_req and rd_req both held continuously for 6 cycles after reset: grants go W,R,W,R,W,R; ram_we pattern 1,0,1,0,1,0.
- Prefill addrs 0..3 with 0xA0..0xA3, rd_rdy=0, request reads of 0..3 back-to-back:
  - only 2 rd_acks occur, then rd_ack stays 0 and rd_vld=1 with rd_data=0xA0 held.
  - After rd_rdy=1, outputs 0xA0,0xA1,0xA2,0xA3 in order with no loss.
- Buffer full (rd_rdy=0) while a write to addr 9 is pending: wr_ack is asserted, the write completes, and rd_ack stays 0.
- Assert rst for 1 cycle with 1 entry buffered and 1 read inflight: next cycle rd_vld=0, no stale data appears later, and the first subsequent tie grants write.
- Streaming reads of addrs 0..15 with rd_rdy=1 constantly: 16 consecutive rd_acks and 16 consecutive rd_vld cycles, each 2 cycles after its ack.
